uart_rx: RTL and testbench

Serial receiver that deserialises 8N1 UART frames arriving on the SOC `RXD` line into bytes. It presents each byte to the CPU-side I/O bus through a one-entry valid/ready holding register. It is the receive end of the link whose transmit end drives `TXD`, and it reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchroniser, mid-bit sampling FSM and a
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  logic          sync1_q;
  logic          rxs_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          overrun_q;

  // Both stages reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // A delivery later in this block overrides this clear.
      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_q <= START;
            cnt_q   <= HALF_LOAD;
          end
        end

        START: begin
          if (cnt_q == '0) begin
            if (rxs_q) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              bit_q   <= '0;
              cnt_q   <= BIT_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rxs_q, shift_q[7:1]};
            cnt_q   <= BIT_LOAD;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == '0) begin
            if (rxs_q) begin
              // Returning to IDLE mid stop bit lets a back-to-back start edge in.
              state_q <= IDLE;
              if (!valid_q || ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (rxs_q) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes/events, a
// negedge monitor pops and compares whenever the receiver presents output.
module tb_uart_rx;

  localparam int CPB      = 8;
  localparam int H        = CPB / 2;
  localparam int STOP_OFS = 2 + H + 9 * CPB;

  localparam int EXP_TIMED   = 0;
  localparam int EXP_UNTIMED = 1;
  localparam int EXP_FE      = 2;
  localparam int EXP_OV      = 3;

  localparam int EV_FE = 1;
  localparam int EV_OV = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } byteExp_t;

  typedef struct {
    int kind;
    int cyc;
  } evExp_t;

  byteExp_t byteQ[$];
  evExp_t   evQ[$];

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) waitCycle();
  endtask

  task automatic idleBits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) waitCycle();
  endtask

  // The outcome lands one cycle after the stop sample, which sits
  // 2 (synchroniser) + H + 9 bit times after the pin falls.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int kind);
    int n;
    n = cyc;
    case (kind)
      EXP_TIMED:   byteQ.push_back(byteExp_t'{b, n + STOP_OFS + 1});
      EXP_UNTIMED: byteQ.push_back(byteExp_t'{b, -1});
      EXP_FE:      evQ.push_back(evExp_t'{EV_FE, n + STOP_OFS + 1});
      EXP_OV:      evQ.push_back(evExp_t'{EV_OV, n + STOP_OFS + 1});
      default:     ;
    endcase
    rxd = 1'b0;
    repeat (CPB) waitCycle();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) waitCycle();
    end
    rxd = stopBit;
    repeat (CPB) waitCycle();
  endtask

  task automatic handleEvent(input int kind);
    evExp_t ev;
    checkOutput("event_expected", int'(evQ.size() > 0), 1);
    if (evQ.size() > 0) begin
      ev = evQ.pop_front();
      checkOutput("event_kind", kind, ev.kind);
      checkOutput("event_cycle", cyc, ev.cyc);
    end
  endtask

  always @(negedge clk) begin
    byteExp_t e;
    if (!reset) begin
      if (valid && ready) begin
        checkOutput("byte_expected", int'(byteQ.size() > 0), 1);
        if (byteQ.size() > 0) begin
          e = byteQ.pop_front();
          checkOutput("data", int'(data), int'(e.data));
          if (e.cyc >= 0) checkOutput("byte_cycle", cyc, e.cyc);
        end
      end
      if (frame_err) handleEvent(EV_FE);
      if (overrun) handleEvent(EV_OV);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] partial;
    logic [7:0] b;
    logic good;

    reset = 1'b1;
    rxd   = 1'b1;
    ready = 1'b1;
    repeat (3) waitCycle();
    reset = 1'b0;
    waitCycle();

    checkOutput("rst_data", int'(data), 0);
    checkOutput("rst_valid", int'(valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_frame_err", int'(frame_err), 0);
    checkOutput("rst_overrun", int'(overrun), 0);

    $display("[TB] exact-baud frame 0xA5");
    n = cyc;
    fork
      applyStimulus(8'hA5, 1'b1, EXP_TIMED);
      begin
        waitUntil(n + 2);
        checkOutput("busy_t0", int'(busy), 0);
        waitUntil(n + 3);
        checkOutput("busy_t0p1", int'(busy), 1);
        waitUntil(n + STOP_OFS);
        checkOutput("busy_stop", int'(busy), 1);
        waitUntil(n + STOP_OFS + 1);
        checkOutput("busy_after", int'(busy), 0);
      end
    join
    idleBits(2);

    $display("[TB] start glitch");
    n = cyc;
    rxd = 1'b0;
    repeat (2) waitCycle();
    rxd = 1'b1;
    waitUntil(n + 3);
    checkOutput("glitch_busy", int'(busy), 1);
    waitUntil(n + 2 + H + 1);
    checkOutput("glitch_idle", int'(busy), 0);
    idleBits(2);

    $display("[TB] framing error then break");
    applyStimulus(8'h3C, 1'b0, EXP_FE);
    rxd = 1'b0;
    repeat (19 * CPB) waitCycle();
    checkOutput("break_busy", int'(busy), 1);
    idleBits(2);
    checkOutput("break_recovered", int'(busy), 0);
    applyStimulus(8'h81, 1'b1, EXP_TIMED);
    idleBits(1);

    $display("[TB] overrun with ready low");
    ready = 1'b0;
    applyStimulus(8'h11, 1'b1, EXP_UNTIMED);
    applyStimulus(8'h22, 1'b1, EXP_OV);
    idleBits(1);
    checkOutput("ovr_data_held", int'(data), 8'h11);
    checkOutput("ovr_valid_held", int'(valid), 1);
    ready = 1'b1;
    waitCycle();
    ready = 1'b0;
    checkOutput("ovr_valid_drop", int'(valid), 0);

    $display("[TB] ready on delivery cycle");
    applyStimulus(8'h11, 1'b1, EXP_UNTIMED);
    idleBits(1);
    n = cyc;
    fork
      applyStimulus(8'h22, 1'b1, EXP_UNTIMED);
      begin
        waitUntil(n + STOP_OFS);
        ready = 1'b1;
        waitCycle();
        ready = 1'b0;
        checkOutput("swap_data", int'(data), 8'h22);
        checkOutput("swap_valid", int'(valid), 1);
        checkOutput("swap_overrun", int'(overrun), 0);
      end
    join
    idleBits(1);
    ready = 1'b1;
    waitCycle();

    $display("[TB] reset mid-frame");
    partial = 8'h5A;
    rxd = 1'b0;
    repeat (CPB) waitCycle();
    for (int i = 0; i < 3; i++) begin
      rxd = partial[i];
      repeat (CPB) waitCycle();
    end
    rxd = partial[3];
    repeat (CPB / 2) waitCycle();
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_data", int'(data), 0);
    checkOutput("mid_rst_valid", int'(valid), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_frame_err", int'(frame_err), 0);
    checkOutput("mid_rst_overrun", int'(overrun), 0);
    waitCycle();
    reset = 1'b0;
    rxd = 1'b1;
    idleBits(2);
    applyStimulus(8'h7E, 1'b1, EXP_TIMED);
    idleBits(1);

    $display("[TB] random frames");
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      applyStimulus(b, good, good ? EXP_TIMED : EXP_FE);
      if (!good) idleBits(1);
      else idleBits(int'($urandom_range(0, 2)));
    end

    idleBits(2);
    checkOutput("bytes_drained", byteQ.size(), 0);
    checkOutput("events_drained", evQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
